// File: rtl/lfsr_rand_arbiter.sv
// Round-robin arbiter that shares one 8-bit LFSR among NREQ requesters.
// Each draw advances the LFSR STEPS times, captures it, then pulses gnt/rand_valid to the winner.
module lfsr_rand_arbiter #(
    parameter int NREQ     = 2,
    parameter int STEPS    = 8,
    parameter int FREE_RUN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [7:0]      lfsr_q,
    output logic            lfsr_step,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      rand_out,
    output logic            rand_valid,
    output logic            busy,
    output logic            lfsr_fault
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ADVANCE = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] GRANT   = 2'd3;

    localparam logic [7:0]       STEPS_INIT = 8'(STEPS);
    localparam logic [PTR_W-1:0] PTR_RST    = PTR_W'(NREQ - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] winner_q, winner_d;
    logic [7:0]       rand_q, rand_d;
    logic             fault_q, fault_d;

    logic             sel_found;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] cand;

    // Search starts just above the last winner, so it becomes lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NREQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        rand_d   = rand_q;
        fault_d  = fault_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    winner_d = sel_idx;
                    cnt_d    = STEPS_INIT;
                    state_d  = ADVANCE;
                end
            end
            ADVANCE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rand_d  = lfsr_q;
                state_d = GRANT;
                if (lfsr_q == 8'h00) begin
                    fault_d = 1'b1;
                end
            end
            GRANT: begin
                ptr_d   = winner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            ptr_q    <= PTR_RST;
            winner_q <= '0;
            rand_q   <= 8'h00;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            rand_q   <= rand_d;
            fault_q  <= fault_d;
        end
    end

    // Outputs decode only registered state, never req, so they cannot glitch.
    always_comb begin
        gnt = '0;
        if (state_q == GRANT) begin
            gnt[winner_q] = 1'b1;
        end
    end

    assign lfsr_step  = (state_q == ADVANCE) || ((state_q == IDLE) && (FREE_RUN != 0));
    assign rand_valid = (state_q == GRANT);
    assign busy       = (state_q != IDLE);
    assign rand_out   = rand_q;
    assign lfsr_fault = fault_q;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Bench for lfsr_rand_arbiter: three configurations, each fed by a bench-side 8-bit LFSR
// (taps 8,6,5,4, seed 0x5A), checked against a draw-level round-robin / step-count model.
module tb_lfsr_rand_arbiter;

    localparam logic [7:0] SEED = 8'h5A;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [1:0] req_a = '0;
    logic [1:0] req_b = '0;
    logic [2:0] req_c = '0;
    logic       force_zero = 1'b0;

    logic [7:0] lfsr_a, lfsr_b, lfsr_c, lfsr_in_a;
    logic       step_a, step_b, step_c;
    logic [1:0] gnt_a, gnt_b;
    logic [2:0] gnt_c;
    logic [7:0] rand_out_a, rand_out_b, rand_out_c;
    logic       rand_valid_a, rand_valid_b, rand_valid_c;
    logic       busy_a, busy_b, busy_c;
    logic       fault_o_a, fault_o_b, fault_o_c;

    // Reference model state for instance a
    int         ptr_a;
    logic [7:0] mdl_lfsr_a;
    logic       mdl_fault_a;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
        logic [7:0] s;
        s = v;
        for (int k = 0; k < n; k++) s = lfsr_next(s);
        return s;
    endfunction

    function automatic int rr_pick(input logic [7:0] r, input int ptr, input int n);
        int idx;
        for (int k = 1; k <= n; k++) begin
            idx = (ptr + k) % n;
            if (r[idx[2:0]]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_a <= SEED;
            lfsr_b <= SEED;
            lfsr_c <= SEED;
        end else begin
            if (step_a) lfsr_a <= lfsr_next(lfsr_a);
            if (step_b) lfsr_b <= lfsr_next(lfsr_b);
            if (step_c) lfsr_c <= lfsr_next(lfsr_c);
        end
    end

    assign lfsr_in_a = force_zero ? 8'h00 : lfsr_a;

    lfsr_rand_arbiter #(.NREQ(2), .STEPS(8), .FREE_RUN(0)) u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .lfsr_q(lfsr_in_a), .lfsr_step(step_a),
        .gnt(gnt_a), .rand_out(rand_out_a), .rand_valid(rand_valid_a), .busy(busy_a),
        .lfsr_fault(fault_o_a)
    );

    lfsr_rand_arbiter #(.NREQ(2), .STEPS(1), .FREE_RUN(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .lfsr_q(lfsr_b), .lfsr_step(step_b),
        .gnt(gnt_b), .rand_out(rand_out_b), .rand_valid(rand_valid_b), .busy(busy_b),
        .lfsr_fault(fault_o_b)
    );

    lfsr_rand_arbiter #(.NREQ(3), .STEPS(5), .FREE_RUN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .lfsr_q(lfsr_c), .lfsr_step(step_c),
        .gnt(gnt_c), .rand_out(rand_out_c), .rand_valid(rand_valid_c), .busy(busy_c),
        .lfsr_fault(fault_o_c)
    );

    task automatic do_reset();
        req_a      = '0;
        req_b      = '0;
        req_c      = '0;
        force_zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        ptr_a       = 1;
        mdl_lfsr_a  = SEED;
        mdl_fault_a = 1'b0;
    endtask

    // One draw on instance a. mode: 0 steady req, 1 drop req after first busy cycle, 2 scramble req while busy.
    task automatic run_draw_a(input string name, input logic [1:0] req_start, input int mode, input bit keep);
        int         w;
        int         lat;
        int         steps;
        int         busy_n;
        bit         seen;
        logic [7:0] exp_val;
        logic [1:0] exp_gnt;
        lat    = 0;
        steps  = 0;
        busy_n = 0;
        seen   = 1'b0;
        w          = rr_pick({6'b0, req_start}, ptr_a, 2);
        mdl_lfsr_a = lfsr_adv(mdl_lfsr_a, 8);
        exp_val    = force_zero ? 8'h00 : mdl_lfsr_a;
        if (exp_val == 8'h00) mdl_fault_a = 1'b1;
        exp_gnt = 2'(1 << w);
        req_a = req_start;
        @(posedge clk);
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (mode == 1 && n == 1) req_a = '0;
            if (mode == 2) req_a = 2'($urandom);
            steps  += int'(step_a);
            busy_n += int'(busy_a);
            if (gnt_a !== 2'b00) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: no gnt within 40 cycles", name);
            return;
        end
        total++;
        if (lat !== 10) begin bad++; $display("FAIL %s latency: got %0d want 10", name, lat); end
        total++;
        if (steps !== 8) begin bad++; $display("FAIL %s step_count: got %0d want 8", name, steps); end
        total++;
        if (busy_n !== 10) begin bad++; $display("FAIL %s busy_cycles: got %0d want 10", name, busy_n); end
        total++;
        if (gnt_a !== exp_gnt) begin bad++; $display("FAIL %s gnt: got %b want %b", name, gnt_a, exp_gnt); end
        total++;
        if (rand_valid_a !== 1'b1) begin bad++; $display("FAIL %s rand_valid: got %b want 1", name, rand_valid_a); end
        total++;
        if (rand_out_a !== exp_val) begin bad++; $display("FAIL %s rand_out: got %h want %h", name, rand_out_a, exp_val); end
        total++;
        if (fault_o_a !== mdl_fault_a) begin bad++; $display("FAIL %s lfsr_fault: got %b want %b", name, fault_o_a, mdl_fault_a); end
        ptr_a = w;
        req_a = (keep && mode == 0) ? req_start : 2'b00;
        @(negedge clk);
        total++;
        if ({gnt_a, rand_valid_a, busy_a, step_a} !== 5'b0) begin
            bad++;
            $display("FAIL %s pulse_end: got gnt=%b valid=%b busy=%b step=%b want all 0",
                     name, gnt_a, rand_valid_a, busy_a, step_a);
        end
        if (!keep) begin
            @(negedge clk);
            total++;
            if (busy_a !== 1'b0) begin bad++; $display("FAIL %s no_redraw: busy got %b want 0", name, busy_a); end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({gnt_a, rand_valid_a, busy_a, fault_o_a, step_a, rand_out_a} !== 14'h0) begin
            bad++;
            $display("FAIL reset_a: got gnt=%b valid=%b busy=%b fault=%b step=%b rand=%h want zeros",
                     gnt_a, rand_valid_a, busy_a, fault_o_a, step_a, rand_out_a);
        end
        total++;
        if ({step_b, step_c, busy_c, gnt_c} !== 6'b010000) begin
            bad++;
            $display("FAIL reset_free_run: got step_b=%b step_c=%b busy_c=%b gnt_c=%b want 0 1 0 000",
                     step_b, step_c, busy_c, gnt_c);
        end
    endtask

    task automatic test_single_draw();
        do_reset();
        run_draw_a("single", 2'b01, 0, 1'b0);
        total++;
        if (rand_out_a !== 8'h45) begin bad++; $display("FAIL single_hold: rand_out got %h want 45", rand_out_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_draw_a("b2b_0", 2'b11, 0, 1'b1);
        total++;
        if (rand_out_a !== 8'h45) begin bad++; $display("FAIL b2b_first_val: got %h want 45", rand_out_a); end
        run_draw_a("b2b_1", 2'b11, 0, 1'b1);
        total++;
        if (rand_out_a !== 8'h2A) begin bad++; $display("FAIL b2b_second_val: got %h want 2a", rand_out_a); end
        run_draw_a("b2b_2", 2'b11, 0, 1'b1);
        run_draw_a("b2b_3", 2'b11, 0, 1'b0);
    endtask

    task automatic test_drop();
        do_reset();
        run_draw_a("drop", 2'b01, 1, 1'b0);
        total++;
        if (rand_out_a !== 8'h45) begin bad++; $display("FAIL drop_val: got %h want 45", rand_out_a); end
    endtask

    // Continues from the drop draw: pointer sits at 0 and rand_out holds 0x45 going in.
    task automatic test_reset_mid();
        int gnt_seen;
        gnt_seen = 0;
        req_a = 2'b11;
        @(posedge clk);
        repeat (3) @(negedge clk);
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy_a); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt_a, rand_valid_a, busy_a, fault_o_a, step_a, rand_out_a} !== 14'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got gnt=%b valid=%b busy=%b fault=%b step=%b rand=%h want zeros",
                     gnt_a, rand_valid_a, busy_a, fault_o_a, step_a, rand_out_a);
        end
        repeat (12) begin
            @(negedge clk);
            if (gnt_a !== 2'b00) gnt_seen++;
        end
        total++;
        if (gnt_seen !== 0) begin bad++; $display("FAIL mid_no_gnt: got %0d grant cycles want 0", gnt_seen); end
        rst_n       = 1'b1;
        ptr_a       = 1;
        mdl_lfsr_a  = SEED;
        mdl_fault_a = 1'b0;
        run_draw_a("post_reset", 2'b11, 0, 1'b0);
    endtask

    task automatic test_lfsr_fault();
        do_reset();
        force_zero = 1'b1;
        run_draw_a("fault_zero", 2'b01, 0, 1'b0);
        force_zero = 1'b0;
        run_draw_a("fault_sticky_1", 2'b10, 0, 1'b0);
        run_draw_a("fault_sticky_2", 2'b11, 0, 1'b0);
        do_reset();
        total++;
        if (fault_o_a !== 1'b0) begin bad++; $display("FAIL fault_clear: got %b want 0", fault_o_a); end
    endtask

    task automatic test_steps1();
        int  lat;
        int  steps;
        int  busy_n;
        bit  seen;
        lat    = 0;
        steps  = 0;
        busy_n = 0;
        seen   = 1'b0;
        do_reset();
        req_b = 2'b10;
        @(posedge clk);
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            steps  += int'(step_b);
            busy_n += int'(busy_b);
            if (gnt_b !== 2'b00) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        req_b = 2'b00;
        total++;
        if (!seen) begin bad++; $display("FAIL s1_timeout: no gnt within 20 cycles"); return; end
        total++;
        if (lat !== 3) begin bad++; $display("FAIL s1_latency: got %0d want 3", lat); end
        total++;
        if (busy_n !== 3 || steps !== 1) begin
            bad++;
            $display("FAIL s1_busy_steps: got busy=%0d steps=%0d want 3 1", busy_n, steps);
        end
        total++;
        if (gnt_b !== 2'b10 || rand_valid_b !== 1'b1) begin
            bad++;
            $display("FAIL s1_gnt: got gnt=%b valid=%b want 10 1", gnt_b, rand_valid_b);
        end
        total++;
        if (rand_out_b !== 8'hB4) begin bad++; $display("FAIL s1_rand_out: got %h want b4", rand_out_b); end
    endtask

    // FREE_RUN=1, NREQ=3: IDLE cycles step the LFSR, so each held-request draw adds STEPS+1 steps.
    task automatic test_free_run();
        int         idle_steps;
        int         lat;
        bit         seen;
        logic [7:0] mdl;
        logic [2:0] exp_gnt;
        idle_steps = 0;
        do_reset();
        repeat (3) begin
            @(negedge clk);
            idle_steps += int'(step_c);
        end
        total++;
        if (idle_steps !== 3) begin bad++; $display("FAIL fr_idle_steps: got %0d want 3", idle_steps); end
        mdl   = lfsr_adv(SEED, 3);
        req_c = 3'b111;
        for (int d = 0; d < 6; d++) begin
            mdl     = lfsr_adv(mdl, 6);
            exp_gnt = 3'(1 << (d % 3));
            seen    = 1'b0;
            lat     = 0;
            @(posedge clk);
            for (int n = 1; n <= 20 && !seen; n++) begin
                @(negedge clk);
                if (gnt_c !== 3'b000) begin
                    seen = 1'b1;
                    lat  = n;
                end
            end
            total++;
            if (!seen || lat !== 7 || gnt_c !== exp_gnt) begin
                bad++;
                $display("FAIL fr_grant_%0d: got lat=%0d gnt=%b want lat=7 gnt=%b", d, lat, gnt_c, exp_gnt);
            end
            total++;
            if (rand_out_c !== mdl) begin bad++; $display("FAIL fr_value_%0d: got %h want %h", d, rand_out_c, mdl); end
            @(negedge clk);
            total++;
            if (busy_c !== 1'b0 || step_c !== 1'b1) begin
                bad++;
                $display("FAIL fr_idle_gap_%0d: got busy=%b step=%b want 0 1", d, busy_c, step_c);
            end
        end
        req_c = 3'b000;
    endtask

    task automatic test_random();
        logic [1:0] rq;
        int         mode;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rq   = 2'($urandom_range(1, 3));
            mode = int'($urandom_range(0, 2));
            run_draw_a($sformatf("rand_%0d", i), rq, mode, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_draw();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_lfsr_fault();
        test_steps1();
        test_free_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
- Shares one 8-bit LFSR random source among NREQ requesters (e.g. the game's delay generator and LED pattern generator).
- Arbitrates requests round-robin, then advances the LFSR a fixed number of steps so consecutive draws are decorrelated.
- Captures the LFSR value and returns it to the winner with a one-cycle grant pulse.
- Sits between the requesters and the LFSR: drives its step enable and reads its q output.

Parameters:
NREQ, 2, number of requesters (1..8)
STEPS, 8, LFSR step pulses issued per draw (1..255)
FREE_RUN, 1, 1 = step the LFSR every IDLE cycle for extra entropy; 0 = step only during draws

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level; held high until the matching gnt pulse
lfsr_q  in  8  current LFSR state
lfsr_step  out  1  step enable to the LFSR
gnt  out  NREQ  one-hot grant pulse, one cycle, coincident with rand_valid
rand_out  out  8  captured random value; held stable until the next capture
rand_valid  out  1  one-cycle pulse, rand_out valid for the granted requester
busy  out  1  high in every state except IDLE
lfsr_fault  out  1  sticky flag: a captured lfsr_q was 0x00 (LFSR lock-up)

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, gnt=0, rand_valid=0, rand_out=0x00, busy=0, lfsr_fault=0.
  - Step counter=0; round-robin pointer ptr=NREQ-1, so req[0] has highest priority first.
  - Reset mid-draw aborts the draw with no grant.
- States: IDLE, ADVANCE, CAPTURE, GRANT.
- IDLE:
  - lfsr_step=FREE_RUN.
  - If any req bit is high: select the winner by searching from index ptr+1 upward, mod NREQ; latch the winner index; load the counter with STEPS; go to ADVANCE.
  - If no req is high, stay in IDLE.
- ADVANCE:
  - lfsr_step=1; the counter decrements each cycle.
  - When counter==1 on a clock edge, go to CAPTURE.
  - Exactly STEPS step pulses are issued.
- CAPTURE:
  - lfsr_step=0.
  - On the edge: rand_out<=lfsr_q, go to GRANT.
  - If lfsr_q==0x00, set lfsr_fault (sticky until reset); the value is still delivered.
- GRANT:
  - lfsr_step=0; gnt[winner]=1; rand_valid=1, for exactly one cycle.
  - ptr<=winner; go to IDLE.
- gnt, rand_valid and busy are decoded from the registered state (glitch-free, no combinational path from req).
- Latency: from the edge on which IDLE samples req to gnt high is STEPS+2 cycles; gnt is high during cycle STEPS+2 after that edge.
  - Back-to-back draws: at least one IDLE cycle separates GRANT and the next ADVANCE.
  - With FREE_RUN=1, that IDLE cycle also steps the LFSR.
- Winner is committed at the IDLE decision:
  - req changes during ADVANCE/CAPTURE/GRANT are ignored.
  - A winner that dropped req still receives its gnt pulse.
  - A requester still high after its grant is re-arbitrated at lowest priority.
- Simultaneous requests: exactly one gnt bit is ever high. With all NREQ held high, grants rotate 0,1,...,NREQ-1,0,...
- NREQ=1: the pointer is a constant; the search degenerates to req[0].

Test Plan:
- NREQ=2, STEPS=8, FREE_RUN=0, LFSR reset seed 0x5A. Pulse reset, raise req[0] -> lfsr_step high 8 cycles; gnt=01 with rand_valid exactly 10 cycles after the sampling edge; rand_out=0x45.
- Same setup, req[0] and req[1] high together and held -> first gnt=01 with rand_out=0x45, then gnt=10 with rand_out=0x2A; the pattern continues alternating.
- STEPS=1, FREE_RUN=0, seed 0x5A, single req[1] -> gnt=10 3 cycles after sampling, rand_out=0xB4, busy high for 3 cycles.
- Drop req[0] one cycle into ADVANCE -> gnt[0] still pulses, rand_out=0x45; no second draw starts.
- Assert rst_n low during ADVANCE -> all outputs return to reset values immediately; no gnt pulse; the next draw starts from the reset pointer (req[0] priority).
- Force lfsr_q=0x00 from the bench -> after one draw lfsr_fault=1 and rand_out=0x00; lfsr_fault stays 1 after later valid draws until rst_n.
